// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/sub sequencer: op encodings and FSM states.
package serial_addsub_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEG  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_full_adder.sv
// Single-bit full adder cell, reused every cycle by the serial sequencer.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Cout
);

  assign Y    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial ADD/SUB/NEG/PASS sequencer, LSB first, one full_adder shared over all bits.
// Optional macro SERIAL_ADDSUB_OVF_EN adds the out_ovf signed-overflow flag.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_cout,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_sum, fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .A    (x_q[0]),
    .B    (y_q[0]),
    .Cin  (carry_q),
    .Y    (fa_sum),
    .Cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    x_d     = x_q;
    y_d     = y_q;
    carry_d = carry_q;
    out_y_d = out_y_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_RUN;
          count_d = '0;
          unique case (in_op)
            OP_ADD:  begin x_d = in_a; y_d = in_b;  carry_d = 1'b0; end
            OP_SUB:  begin x_d = in_a; y_d = ~in_b; carry_d = 1'b1; end
            OP_NEG:  begin x_d = '0;   y_d = ~in_a; carry_d = 1'b1; end
            OP_PASS: begin x_d = in_a; y_d = '0;    carry_d = 1'b0; end
          endcase
        end
      end
      ST_RUN: begin
        // Sum bits enter at the MSB of x, so x holds the full result after WIDTH shifts.
        x_d     = {fa_sum, x_q[WIDTH-1:1]};
        y_d     = {1'b0, y_q[WIDTH-1:1]};
        carry_d = fa_cout;
        if (count_q == LAST) begin
          state_d = ST_DONE;
          out_y_d = {fa_sum, x_q[WIDTH-1:1]};
          cout_d  = fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      out_y_q <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      x_q     <= x_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      out_y_q <= out_y_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_y     = out_y_q;
  assign out_cout  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl; out_ovf is checked when SERIAL_ADDSUB_OVF_EN is set.
module tb_serial_addsub_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_cout;
  logic             busy;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             out_ovf;
`endif

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_cout  (out_cout),
`ifdef SERIAL_ADDSUB_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;
    int               acc;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic seen_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: latency check on the first valid cycle, value checks on the handshake.
  always @(negedge clk) begin
    if (reset) begin
      seen_valid <= 1'b0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got out_y=%0h with empty scoreboard", out_y);
      end else begin
        // Accept edge is cycle 0; result visible after edge WIDTH (WIDTH+1 with request cycle).
        if (!seen_valid) begin
          check({sb[0].name, "_latency"}, cyc - sb[0].acc, WIDTH);
          seen_valid <= 1'b1;
        end
        if (out_ready) begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_y"}, out_y, e.y);
          check({e.name, "_cout"}, out_cout, e.cout);
`ifdef SERIAL_ADDSUB_OVF_EN
          check({e.name, "_ovf"}, out_ovf, e.ovf);
`endif
          seen_valid <= 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] y, input logic cout, input logic ovf,
                       input string name);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got in_ready=0 expected 1 within 60 cycles", name);
      return;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    e.y = y; e.cout = cout; e.ovf = ovf; e.acc = cyc; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    // Scramble inputs during RUN; the result must not depend on them.
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_op    = ~op;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, sb.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_y", out_y, 8'h00);
    check("rst_out_cout", out_cout, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    issue(2'b10, 8'h05, 8'h00, 8'hFB, 1'b0, 1'b0, "neg05");
    check("run_busy", busy, 1'b1);
    check("run_in_ready", in_ready, 1'b0);
    issue(2'b01, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, "sub03_05");
    issue(2'b01, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0, "sub05_03");
    issue(2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "addFF_01");
    issue(2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "add7F_01");
    issue(2'b10, 8'h80, 8'h33, 8'h80, 1'b0, 1'b1, "neg80");
    issue(2'b00, 8'h3C, 8'h5A, 8'h96, 1'b0, 1'b1, "add3C_5A");
    issue(2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, "sub80_01");
    issue(2'b11, 8'hA5, 8'hFF, 8'hA5, 1'b0, 1'b0, "passA5");
    wait_idle("vectors");

    // Backpressure: result must hold in DONE while out_ready is low.
    out_ready = 1'b0;
    issue(2'b00, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, "add12_34");
    begin
      int n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (5) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_y", out_y, 8'h46);
      check("hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle("hold");
    check("hold_idle_busy", busy, 1'b0);
    check("hold_keep_y", out_y, 8'h46);

    // Reset in the middle of RUN discards the operation.
    issue(2'b00, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, "aborted");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    void'(sb.pop_back());
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_y", out_y, 8'h00);
    check("abort_out_cout", out_cout, 1'b0);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    issue(2'b00, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, "add01_01");
    wait_idle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
